// File: rtl/rom_port_arbiter.sv
// Arbitrates ROM download writes and two CPU ROM fetch ports onto one req/ack-toggle SDRAM port.
// Define ROM_ARB_STATS_EN to add the hit_cnt/miss_cnt/max_wait statistics outputs.
module rom_port_arbiter #(
  parameter int unsigned   AW        = 23,
  parameter logic [AW-1:0] CPU1_BASE = AW'(32'h0000_0000),
  parameter logic [AW-1:0] CPU2_BASE = AW'(32'h0000_8000)
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          cpu1_cs,
  input  logic [15:0]   cpu1_addr,
  output logic [7:0]    cpu1_q,
  output logic          cpu1_valid,
  input  logic          cpu2_cs,
  input  logic [15:0]   cpu2_addr,
  output logic [7:0]    cpu2_q,
  output logic          cpu2_valid,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [AW-1:0] mem_a,
  output logic [1:0]    mem_ds,
  output logic          mem_we,
  output logic [15:0]   mem_d,
  input  logic [15:0]   mem_q,
  output logic          overflow
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt,
  output logic [7:0]    max_wait
`endif
);

  localparam int unsigned DW = 16;
  localparam int unsigned TW = 15;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FILL} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_ack_s1;
  logic            r_ack_s2;
  logic            r_mem_req;
  logic [AW-1:0]   r_mem_a;
  logic [1:0]      r_mem_ds;
  logic            r_mem_we;
  logic [DW-1:0]   r_mem_d;
  logic            r_overflow;
  logic            r_dl_wr_d;
  logic            r_dl_act_d;
  logic            r_wb_full;
  logic [AW:0]     r_wb_addr;
  logic [7:0]      r_wb_data;
  logic [DW-1:0]   r_lat1;
  logic [DW-1:0]   r_lat2;
  logic [TW-1:0]   r_tag1;
  logic [TW-1:0]   r_tag2;
  logic            r_lv1;
  logic            r_lv2;
  logic            r_rr;
  logic            r_own;
  logic [TW-1:0]   r_pend_tag;

  logic            w_busy;
  logic            w_dl_edge;
  logic            w_dl_rise;
  logic            w_hit1;
  logic            w_hit2;
  logic            w_miss1;
  logic            w_miss2;
  logic            w_iss_wr;
  logic            w_iss_rd1;
  logic            w_iss_rd2;
  logic            w_iss_rd;
  logic [AW-1:0]   w_rd_addr;
  logic            w_unused;

  // dl_addr bits above the SDRAM byte range are ignored
  assign w_unused  = ^dl_addr;

  assign w_busy    = (r_mem_req != r_ack_s2);
  assign w_dl_edge = dl_active & dl_wr & ~r_dl_wr_d;
  assign w_dl_rise = dl_active & ~r_dl_act_d;

  assign w_hit1    = r_lv1 & (r_tag1 == cpu1_addr[15:1]);
  assign w_hit2    = r_lv2 & (r_tag2 == cpu2_addr[15:1]);
  assign w_miss1   = cpu1_cs & ~w_hit1 & ~dl_active;
  assign w_miss2   = cpu2_cs & ~w_hit2 & ~dl_active;

  assign cpu1_valid = cpu1_cs & w_hit1 & ~dl_active;
  assign cpu2_valid = cpu2_cs & w_hit2 & ~dl_active;
  assign cpu1_q     = cpu1_addr[0] ? r_lat1[15:8] : r_lat1[7:0];
  assign cpu2_q     = cpu2_addr[0] ? r_lat2[15:8] : r_lat2[7:0];

  assign w_iss_rd  = w_iss_rd1 | w_iss_rd2;
  assign w_rd_addr = w_iss_rd2 ? (CPU2_BASE + AW'(cpu2_addr[15:1]))
                               : (CPU1_BASE + AW'(cpu1_addr[15:1]));

  assign mem_req  = r_mem_req;
  assign mem_a    = r_mem_a;
  assign mem_ds   = r_mem_ds;
  assign mem_we   = r_mem_we;
  assign mem_d    = r_mem_d;
  assign overflow = r_overflow;

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and issue selection: buffered write first, then round-robin CPU misses
  always_comb begin
    w_state_nxt = r_state;
    w_iss_wr    = 1'b0;
    w_iss_rd1   = 1'b0;
    w_iss_rd2   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_wb_full) begin
          w_iss_wr    = 1'b1;
          w_state_nxt = S_BUSY;
        end else if (w_miss1 && (!w_miss2 || !r_rr)) begin
          w_iss_rd1   = 1'b1;
          w_state_nxt = S_BUSY;
        end else if (w_miss2) begin
          w_iss_rd2   = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!w_busy) w_state_nxt = r_mem_we ? S_IDLE : S_FILL;
      end
      S_FILL:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ack synchronizer and input edge history
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_s1   <= 1'b0;
      r_ack_s2   <= 1'b0;
      r_dl_wr_d  <= 1'b0;
      r_dl_act_d <= 1'b0;
    end else begin
      r_ack_s1   <= mem_ack;
      r_ack_s2   <= r_ack_s1;
      r_dl_wr_d  <= dl_wr;
      r_dl_act_d <= dl_active;
    end
  end

  // SDRAM command registers, round-robin pointer and pending-read bookkeeping
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_req  <= 1'b0;
      r_mem_a    <= '0;
      r_mem_ds   <= 2'b00;
      r_mem_we   <= 1'b0;
      r_mem_d    <= '0;
      r_rr       <= 1'b0;
      r_own      <= 1'b0;
      r_pend_tag <= '0;
    end else if (w_iss_wr) begin
      r_mem_req  <= ~r_mem_req;
      r_mem_a    <= r_wb_addr[AW:1];
      r_mem_ds   <= {r_wb_addr[0], ~r_wb_addr[0]};
      r_mem_we   <= 1'b1;
      r_mem_d    <= {r_wb_data, r_wb_data};
    end else if (w_iss_rd) begin
      r_mem_req  <= ~r_mem_req;
      r_mem_a    <= w_rd_addr;
      r_mem_ds   <= 2'b11;
      r_mem_we   <= 1'b0;
      r_mem_d    <= '0;
      r_rr       <= w_iss_rd1;
      r_own      <= w_iss_rd2;
      r_pend_tag <= w_iss_rd2 ? cpu2_addr[15:1] : cpu1_addr[15:1];
    end
  end

  // One-entry download buffer; a slot freed by this cycle's issue may be refilled at once
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_full  <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_overflow <= 1'b0;
    end else if (w_dl_edge) begin
      if (r_wb_full && !w_iss_wr) begin
        r_overflow <= 1'b1;
      end else begin
        r_wb_full  <= 1'b1;
        r_wb_addr  <= dl_addr[AW:0];
        r_wb_data  <= dl_data;
      end
    end else if (w_iss_wr) begin
      r_wb_full  <= 1'b0;
    end
  end

  // CPU read latches; download start invalidates both, overriding a same-cycle fill
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_lat1 <= '0;
      r_lat2 <= '0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_lv1  <= 1'b0;
      r_lv2  <= 1'b0;
    end else begin
      if (r_state == S_FILL) begin
        if (!r_own) begin
          r_lat1 <= mem_q;
          r_tag1 <= r_pend_tag;
          r_lv1  <= 1'b1;
        end else begin
          r_lat2 <= mem_q;
          r_tag2 <= r_pend_tag;
          r_lv2  <= 1'b1;
        end
      end
      if (w_dl_rise) begin
        r_lv1 <= 1'b0;
        r_lv2 <= 1'b0;
      end
    end
  end

`ifdef ROM_ARB_STATS_EN
  logic        r_v1_d;
  logic        r_v2_d;
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  logic [7:0]  r_wait;
  logic [7:0]  r_max_wait;
  logic [1:0]  w_hit_inc;
  logic [16:0] w_hit_sum;

  assign w_hit_inc = 2'(cpu1_valid & ~r_v1_d) + 2'(cpu2_valid & ~r_v2_d);
  assign w_hit_sum = 17'(r_hit_cnt) + 17'(w_hit_inc);

  // Saturating statistics; wait time runs from issue until the synchronized ack matches
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_v1_d     <= 1'b0;
      r_v2_d     <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wait     <= '0;
      r_max_wait <= '0;
    end else begin
      r_v1_d    <= cpu1_valid;
      r_v2_d    <= cpu2_valid;
      r_hit_cnt <= w_hit_sum[16] ? 16'hFFFF : w_hit_sum[15:0];
      if (w_iss_rd && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
      if (w_iss_wr || w_iss_rd) begin
        r_wait <= 8'd1;
      end else if (r_state == S_BUSY) begin
        if (w_busy) begin
          if (r_wait != 8'hFF) r_wait <= r_wait + 8'd1;
        end else if (r_wait > r_max_wait) begin
          r_max_wait <= r_wait;
        end
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign max_wait = r_max_wait;
`endif

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares one toggle-handshake SDRAM port between three requesters: ROM download writes, main-CPU ROM fetches and sound-CPU ROM fetches.
- Sits between the data_io download stream and CPU ROM buses on one side, and an sdram port on the other (req/ack toggle, 16-bit words, byte strobes).
- Each CPU gets a one-word read latch, so consecutive byte fetches from the same word cost one SDRAM access.

Parameters:
- AW, 23, SDRAM word-address width.
- CPU1_BASE, 23'h0000, word base of main-CPU ROM region.
- CPU2_BASE, 23'h8000, word base of sound-CPU ROM region.

Ports:
- clk_sys  in  1  system clock; everything on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dl_active  in  1  ROM download in progress.
- dl_wr  in  1  download byte strobe; may be held >1 cycle, rising edge = one byte.
- dl_addr  in  25  download byte address.
- dl_data  in  8  download byte.
- cpu1_cs  in  1  main-CPU ROM read request (level).
- cpu1_addr  in  16  main-CPU byte address.
- cpu1_q  out  8  byte from latch, selected by cpu1_addr[0] (1 = [15:8]).
- cpu1_valid  out  1  cpu1_q valid for current cpu1_addr.
- cpu2_cs, cpu2_addr, cpu2_q, cpu2_valid: as cpu1, for the sound CPU.
- mem_req  out  1  toggles once per new SDRAM access.
- mem_ack  in  1  toggles on completion; from clk_ram domain.
- mem_a  out  AW  word address.
- mem_ds  out  2  byte strobes {hi, lo}.
- mem_we  out  1  1 = write.
- mem_d  out  16  write data; byte replicated on both halves.
- mem_q  in  16  read data; stable once mem_ack has toggled.
- overflow  out  1  sticky: a download byte was lost.

Behaviour:
- Reset (async, reset_n=0): mem_req=0, mem_a=0, mem_ds=0, mem_we=0, mem_d=0, cpuN_valid=0, cpuN_q=0, overflow=0, both latch-valid bits cleared, FSM=IDLE, round-robin pointer=cpu1, pending-write buffer empty.
- Reset mid-access: deassertion returns to IDLE; the in-flight ack is not awaited.
- mem_ack handling: pass through a 2-flop synchronizer to get ack_s. Busy = (mem_req != ack_s).
- FSM states: IDLE, BUSY, FILL.
- IDLE: select the highest-priority pending source, drive mem_a/ds/we/d, toggle mem_req, go to BUSY. Issue happens in the same cycle as the selection.
- Priority: pending download write first, then CPU misses in round-robin order. The pointer flips to the other CPU after each CPU access is granted.
- BUSY: wait until mem_req == ack_s. Reads go to FILL; writes go to IDLE.
- FILL (one cycle): capture mem_q into the owning CPU latch, store tag = word address, set its latch-valid bit, return to IDLE.
- CPU hit: cpuN_valid = cpuN_cs & latch_vN & (tagN == cpuN_addr[15:1]). This is combinational from registered latch state.
- CPU miss: cpuN_cs with no hit. Fetch word address = CPUn_BASE + cpuN_addr[15:1]. Minimum miss-to-valid latency is 1 (issue) + ack round trip + 2 (sync) + 1 (FILL).
- Address change: if the address changes while a fetch is in flight, the completed word still fills the latch; valid stays low until the tag matches, and a new miss is issued from IDLE.
- cpuN_cs low: no request issued; the latch is retained.
- Download write:
  - Captured on rising edge of dl_wr while dl_active=1, into a 1-entry buffer.
  - Issued as mem_a = dl_addr[AW:1], mem_ds = {dl_addr[0], ~dl_addr[0]}, mem_we=1, mem_d = {dl_data, dl_data}.
  - If the buffer is full on a new edge: overflow <= 1 and the new byte is dropped; the buffered byte is kept.
- Rising edge of dl_active: clears both latch-valid bits. Whenever dl_active=1, both cpuN_valid=0 and no CPU reads are issued.
- Simultaneous dl_wr edge and a FILL completion: both take effect in the same cycle.

Optional Feature:
- Macro: ROM_ARB_STATS_EN.
- With the macro defined, extra outputs are added:
  - hit_cnt[15:0] and miss_cnt[15:0]: saturating counters, summed over both CPUs. A hit counts once per cycle with cpuN_valid rising; a miss counts once per CPU read issued.
  - max_wait[7:0]: longest IDLE-issue-to-ack cycle count, saturating at 255.
  - All cleared by reset_n.
- Without the macro, these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: reset_n=0 mid-BUSY -> all outputs 0 immediately; after release, FSM is IDLE and mem_req=0.
- Download bytes: 0x12 @0, 0x34 @1 with model ack delay 4 -> two mem_req toggles; writes (a=0, ds=01, d=1212) then (a=0, ds=10, d=3434); overflow=0.
- Overflow: three dl_wr edges 1 cycle apart with ack delay 10 -> overflow=1; exactly two writes reach memory.
- CPU hit: cpu1 reads 0x0100 then 0x0101, model word 0xBEEF -> one read (a=CPU1_BASE+0x80); q=EF then BE; second byte valid with no new mem_req.
- Arbitration: cpu1 and cpu2 miss in the same cycle -> cpu1 served first, cpu2 next (a=0x8000+addr>>1); a cpu1 miss repeated before the cpu2 grant is served after cpu2.
- Invalidate: after a hit, pulse dl_active -> cpuN_valid=0; the next same-address read issues a fresh SDRAM read.
